// File: rtl/dac_spi_writer_if.sv
// Sample handshake from the function generator plus the serial DAC pins.
// The writer takes the slave side; the upstream/bench takes the master side.
interface dac_spi_writer_if;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        sclk;
    logic        sync_n;
    logic        sdo;
    logic        frame_done;

    modport master (
        output sample, sample_valid,
        input  sample_ready, sclk, sync_n, sdo, frame_done
    );

    modport slave (
        input  sample, sample_valid,
        output sample_ready, sclk, sync_n, sdo, frame_done
    );
endinterface

// File: rtl/dac_spi_writer.sv
// Serialises 12-bit DAC codes into 16-bit SPI frames, MSB first.
// SCLK idles high; the DAC samples sdo on each falling sclk edge.
module dac_spi_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dac_spi_writer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT_HI, SHIFT_LO, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [14:0] r_shift;
    logic        r_sclk;
    logic        r_sync_n;
    logic        r_sdo;
    logic        r_done;
    logic        r_ready;
    logic [15:0] w_frame;

    assign w_frame = {4'b0000, bus.sample};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b1;
            r_sync_n <= 1'b1;
            r_sdo    <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_ready && bus.sample_valid) begin
                        // bit 15 goes out now, the remaining 15 are held for shifting
                        r_sdo    <= w_frame[15];
                        r_shift  <= w_frame[14:0];
                        r_sync_n <= 1'b0;
                        r_sclk   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        r_state  <= SHIFT_HI;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= SHIFT_LO;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                SHIFT_LO: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= 1'b1;
                        if (r_bit == 4'd15) begin
                            r_sync_n <= 1'b1;
                            r_sdo    <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= GAP;
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_sdo   <= r_shift[14];
                            r_shift <= {r_shift[13:0], 1'b0};
                            r_state <= SHIFT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sclk         = r_sclk;
    assign bus.sync_n       = r_sync_n;
    assign bus.sdo          = r_sdo;
    assign bus.frame_done   = r_done;
    assign bus.sample_ready = r_ready;

endmodule

// File: doc/dac_spi_writer.md
DAC_SPI_WRITER -- requirements
Module: dac_spi_writer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, which sets the SCLK half-period in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, which sets the minimum number of clk cycles sync_n stays high between frames (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sample, input, 12 bits: the unsigned DAC code from the upstream function generator.
REQ-006 The block SHALL have port sample_valid, input, 1 bit: asserted when sample holds a value to be sent.
REQ-007 The block SHALL have port sample_ready, output, 1 bit: asserted when the block can accept a sample.
REQ-008 The block SHALL have port sclk, output, 1 bit: the serial clock to the DAC.
REQ-009 The block SHALL have port sync_n, output, 1 bit: the active-low frame select to the DAC.
REQ-010 The block SHALL have port sdo, output, 1 bit: serial data to the DAC, MSB first.
REQ-011 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of each frame.

Function
REQ-012 The state machine SHALL have exactly four states: IDLE, SHIFT_HI, SHIFT_LO and GAP. All outputs SHALL be registered.
REQ-013 A sample SHALL be accepted on the rising edge where sample_valid && sample_ready; sample_ready SHALL be 1 only in IDLE.
REQ-014 On acceptance, the block SHALL capture the 16-bit frame {4'b0000, sample}, and later changes on sample SHALL NOT affect the frame in flight.
REQ-015 At the accept edge the block SHALL set sync_n<=0, sclk<=1, sdo<=frame[15] and sample_ready<=0, and SHALL enter SHIFT_HI.
REQ-016 In SHIFT_HI, sclk SHALL be held at 1 for CLK_DIV cycles, then the block SHALL go to SHIFT_LO with sclk<=0; that falling edge is where the DAC samples sdo.
REQ-017 In SHIFT_LO, sclk SHALL be held at 0 for CLK_DIV cycles, then sclk<=1 and the bit index SHALL advance.
REQ-018 sdo SHALL change only on sclk rising edges, presenting frame[15-i] for bit i.
REQ-019 After bit 0's SHIFT_LO completes, the block SHALL set sync_n<=1, sclk<=1, sdo<=0 and frame_done<=1 for one cycle, and SHALL enter GAP.
REQ-020 sync_n SHALL be low for exactly 32*CLK_DIV clk cycles per frame, with exactly 16 sclk falling edges while it is low.
REQ-021 GAP SHALL last GAP_CYCLES cycles and then return to IDLE with sample_ready=1.
REQ-022 Throughput SHALL be one frame per 1 + 32*CLK_DIV + GAP_CYCLES cycles at most; with the defaults this is 67 cycles.
REQ-023 A sample_valid held high through GAP SHALL be accepted on the first IDLE cycle, with no lost or duplicated frames.
REQ-024 A sample_valid pulse while sample_ready=0 SHALL be ignored, with no buffering.
REQ-025 The codes 12'h000 and 12'hFFF SHALL be transmitted unmodified, with no wrap or saturation logic.
REQ-026 In IDLE the outputs SHALL be sclk=1, sync_n=1, sdo=0 and frame_done=0.

Reset
REQ-027 While rst=1, at each rising clk edge the outputs SHALL become sclk=1, sync_n=1, sdo=0, frame_done=0 and sample_ready=0, and the state SHALL become IDLE.
REQ-028 sample_ready SHALL read 1 from the first clk edge after rst deasserts, provided sample_valid is not yet being accepted.
REQ-029 An rst asserted mid-frame SHALL abort the frame: sync_n SHALL read 1 at the next edge, the captured sample SHALL be discarded, and no frame_done SHALL be produced.

Verification
REQ-030 Basic frame: CLK_DIV=2, GAP_CYCLES=2, sample=12'hA5C with a one-cycle valid -> sdo captured on 16 sclk falls = 16'h0A5C, sync_n low for 64 cycles, a single frame_done pulse.
REQ-031 Back-to-back: valid held high with 12'h001 followed by 12'hFFF -> frames 16'h0001 and 16'h0FFF, with accept edges 67 cycles apart.
REQ-032 Input stability: sample changed to 12'h123 during the shift of 12'h800 -> the DAC model receives 16'h0800.
REQ-033 Mid-frame reset: rst for 1 cycle after the 5th sclk fall -> sync_n=1 next edge, no frame_done, sample_ready=1 one cycle after rst drops, and the next frame is intact.
REQ-034 Divider extremes: CLK_DIV=1 and CLK_DIV=255 with sample=12'h555 -> correct 16'h0555, and sync_n low for 32 and 8160 cycles respectively.
REQ-035 Ignored valid: a one-cycle valid with 12'h7FF while busy -> no extra frame is ever sent.
